// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if
// Groups the stopwatch front-end signals: two raw pushbuttons in, and the
// count tick, clear pulse and run indicator out.
//   btn_ss  : raw Start/Stop button, active-high, asynchronous, may bounce
//   btn_clr : raw Clear button, active-high, asynchronous, may bounce
//   enable  : one-cycle count tick to the stopwatch counter
//   clear   : one-cycle pulse to the stopwatch synchronous reset
//   running : high while the controller is in RUN
// master drives the buttons (board / bench side); slave is the controller.
interface stopwatch_ctrl_if;
  logic btn_ss;
  logic btn_clr;
  logic enable;
  logic clear;
  logic running;

  modport master (
    output btn_ss,
    output btn_clr,
    input  enable,
    input  clear,
    input  running
  );

  modport slave (
    input  btn_ss,
    input  btn_clr,
    output enable,
    output clear,
    output running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Front-end controller for the stopwatch counter. Synchronizes and debounces
// the Start/Stop and Clear pushbuttons, runs an IDLE/RUN/PAUSE state machine
// and emits count ticks every DIV clocks while running.
//   Parameters:
//     DIV       : system clocks per counter tick (>= 1)
//     DB_CYCLES : consecutive stable clocks needed to accept a button change (>= 1)
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : stopwatch_ctrl_if.slave (btn_ss, btn_clr in; enable, clear, running out)
module stopwatch_ctrl #(
  parameter int DIV       = 100000,
  parameter int DB_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  stopwatch_ctrl_if.slave   bus
);

  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  // Bit 0 carries Start/Stop, bit 1 carries Clear throughout the button path.
  logic [1:0]      raw;
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      stable;
  logic [1:0]      stable_prev;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             clear_nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic             run_hold;

  assign raw = {bus.btn_clr, bus.btn_ss};

  // Two-flop synchronizer, then a per-button debouncer: the accepted level
  // only follows s2 after DB_CYCLES consecutive disagreeing samples, and any
  // agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= '0;
      s2          <= '0;
      stable      <= '0;
      stable_prev <= '0;
      db_cnt[0]   <= '0;
      db_cnt[1]   <= '0;
    end else begin
      s1          <= raw;
      s2          <= s1;
      stable_prev <= stable;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level: a held button gives a single press.
  assign press = stable & ~stable_prev;

  // Clear only acts while stopped and wins over Start/Stop there; in RUN a
  // simultaneous Clear is ignored and Start/Stop pauses.
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (press[1]) begin
          clear_nxt = 1'b1;
        end else if (press[0]) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (press[0]) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (press[1]) begin
          state_nxt = IDLE;
          clear_nxt = 1'b1;
        end else if (press[0]) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.running <= 1'b0;
      bus.clear   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.running <= (state_nxt == RUN);
      bus.clear   <= clear_nxt;
    end
  end

  // Counting only proceeds when RUN was already held and is kept this edge,
  // so entry zeroes the prescaler and leaving RUN kills any pending tick.
  assign run_hold = (state == RUN) && (state_nxt == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      bus.enable <= 1'b0;
    end else if (run_hold) begin
      if (pre_cnt == PRE_MAX) begin
        pre_cnt    <= '0;
        bus.enable <= 1'b1;
      end else begin
        pre_cnt    <= pre_cnt + PRE_W'(1);
        bus.enable <= 1'b0;
      end
    end else begin
      pre_cnt    <= '0;
      bus.enable <= 1'b0;
    end
  end

endmodule
